// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default sizing for the register write arbiter.
package reg_write_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: chooses the lowest requesting index at or
// above the pointer, wrapping to the lowest requesting index below it.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    logic found;

    // Two ordered scans: first the upper window starting at ptr, then a wrap scan.
    always_comb begin
        valid = |req;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared
// enabled register bank: IDLE picks a winner, WRITE pulses the enable, ACK
// pulses the winner's acknowledge and advances the rotation pointer.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int W     = DEFAULT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       reg_en,
    output logic [W-1:0]               reg_d,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] ptr;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_index;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign busy = (state != IDLE);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a write, once started, always runs through ACK.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = WRITE;
            WRITE:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered datapath: winner and data are captured on entry to WRITE so
    // later req/req_data changes cannot disturb the committed write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            grant_id <= '0;
            reg_d    <= '0;
            reg_en   <= 1'b0;
            ack      <= '0;
        end else begin
            reg_en <= 1'b0;
            ack    <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_index;
                        reg_d    <= req_data[int'(pick_index)*W +: W];
                        reg_en   <= 1'b1;
                    end
                end
                WRITE: begin
                    ack <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                end
                ACK: begin
                    if (grant_id == IDX_W'(N_REQ-1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (N_REQ=4, W=8).
module tb_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        reg_en;
    logic [7:0]  reg_d;
    logic        busy;
    logic [1:0]  grant_id;

    int checks;
    int errors;

    reg_write_arbiter #(
        .N_REQ (4),
        .W     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        #2;
        checks++; if (reg_en !== 1'b0)   begin errors++; $display("[TB] FAIL reset_reg_en: got %b expected 0", reg_en); end
        checks++; if (ack !== 4'b0000)   begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (reg_d !== 8'h00)   begin errors++; $display("[TB] FAIL reset_reg_d: got %h expected 00", reg_d); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (dut.ptr !== 2'd0)  begin errors++; $display("[TB] FAIL reset_ptr: got %0d expected 0", dut.ptr); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        req            = 4'b0001;
        req_data[7:0]  = 8'h5A;
        @(negedge clk);
        checks++; if (reg_en !== 1'b1)   begin errors++; $display("[TB] FAIL single_reg_en: got %b expected 1", reg_en); end
        checks++; if (reg_d !== 8'h5A)   begin errors++; $display("[TB] FAIL single_reg_d: got %h expected 5a", reg_d); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL single_grant: got %0d expected 0", grant_id); end
        checks++; if (ack !== 4'b0000)   begin errors++; $display("[TB] FAIL single_ack_early: got %b expected 0000", ack); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if (ack !== 4'b0001)   begin errors++; $display("[TB] FAIL single_ack: got %b expected 0001", ack); end
        checks++; if (reg_en !== 1'b0)   begin errors++; $display("[TB] FAIL single_reg_en_off: got %b expected 0", reg_en); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 4'b0000)   begin errors++; $display("[TB] FAIL single_ack_off: got %b expected 0000", ack); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
        checks++; if (dut.ptr !== 2'd1)  begin errors++; $display("[TB] FAIL single_ptr: got %0d expected 1", dut.ptr); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_id;
        logic [7:0] exp_d;
        logic [3:0] exp_ack;
        pulse_reset();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_id  = 2'(g % 4);
            exp_d   = 8'h10 + 8'(g % 4);
            exp_ack = 4'b0001 << exp_id;
            @(negedge clk);
            checks++; if (reg_en !== 1'b1)    begin errors++; $display("[TB] FAIL contention_reg_en[%0d]: got %b expected 1", g, reg_en); end
            checks++; if (reg_d !== exp_d)    begin errors++; $display("[TB] FAIL contention_reg_d[%0d]: got %h expected %h", g, reg_d, exp_d); end
            checks++; if (grant_id !== exp_id) begin errors++; $display("[TB] FAIL contention_grant[%0d]: got %0d expected %0d", g, grant_id, exp_id); end
            @(negedge clk);
            checks++; if (ack !== exp_ack)    begin errors++; $display("[TB] FAIL contention_ack[%0d]: got %b expected %b", g, ack, exp_ack); end
            checks++; if (reg_en !== 1'b0)    begin errors++; $display("[TB] FAIL contention_reg_en_off[%0d]: got %b expected 0", g, reg_en); end
            @(negedge clk);
            checks++; if (ack !== 4'b0000)    begin errors++; $display("[TB] FAIL contention_ack_off[%0d]: got %b expected 0000", g, ack); end
            checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL contention_idle[%0d]: got %b expected 0", g, busy); end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [1:0] exp_ids [2];
        logic [7:0] exp_ds  [2];
        logic [1:0] exp_ptr [2];
        exp_ids[0] = 2'd0; exp_ds[0] = 8'hA0; exp_ptr[0] = 2'd1;
        exp_ids[1] = 2'd2; exp_ds[1] = 8'hC2; exp_ptr[1] = 2'd3;
        @(negedge clk);
        pulse_reset();
        req_data[7:0]   = 8'hA0;
        req_data[23:16] = 8'hC2;
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant_id !== 2'd2) begin errors++; $display("[TB] FAIL wrap_setup_grant: got %0d expected 2", grant_id); end
        @(negedge clk);
        checks++; if (ack !== 4'b0100)   begin errors++; $display("[TB] FAIL wrap_setup_ack: got %b expected 0100", ack); end
        req = 4'b0101;
        @(negedge clk);
        checks++; if (dut.ptr !== 2'd3)  begin errors++; $display("[TB] FAIL wrap_setup_ptr: got %0d expected 3", dut.ptr); end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            checks++; if (grant_id !== exp_ids[g]) begin errors++; $display("[TB] FAIL wrap_grant[%0d]: got %0d expected %0d", g, grant_id, exp_ids[g]); end
            checks++; if (reg_d !== exp_ds[g])     begin errors++; $display("[TB] FAIL wrap_reg_d[%0d]: got %h expected %h", g, reg_d, exp_ds[g]); end
            @(negedge clk);
            checks++; if (ack !== (4'b0001 << exp_ids[g])) begin errors++; $display("[TB] FAIL wrap_ack[%0d]: got %b expected %b", g, ack, 4'b0001 << exp_ids[g]); end
            @(negedge clk);
            checks++; if (dut.ptr !== exp_ptr[g])  begin errors++; $display("[TB] FAIL wrap_ptr[%0d]: got %0d expected %0d", g, dut.ptr, exp_ptr[g]); end
        end
        req = 4'b0000;
    endtask

    task automatic test_withdraw();
        req_data[23:16] = 8'h33;
        req = 4'b0100;
        @(negedge clk);
        checks++; if (reg_en !== 1'b1)   begin errors++; $display("[TB] FAIL withdraw_reg_en: got %b expected 1", reg_en); end
        checks++; if (reg_d !== 8'h33)   begin errors++; $display("[TB] FAIL withdraw_reg_d: got %h expected 33", reg_d); end
        req = 4'b0000;
        req_data[23:16] = 8'hFF;
        @(negedge clk);
        checks++; if (ack !== 4'b0100)   begin errors++; $display("[TB] FAIL withdraw_ack: got %b expected 0100", ack); end
        checks++; if (reg_d !== 8'h33)   begin errors++; $display("[TB] FAIL withdraw_hold_ack: got %h expected 33", reg_d); end
        @(negedge clk);
        checks++; if (reg_d !== 8'h33)   begin errors++; $display("[TB] FAIL withdraw_hold_idle: got %h expected 33", reg_d); end
        checks++; if (reg_en !== 1'b0)   begin errors++; $display("[TB] FAIL withdraw_reg_en_off: got %b expected 0", reg_en); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL withdraw_no_regrant: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        req_data[7:0] = 8'h77;
        req = 4'b0001;
        @(negedge clk);
        checks++; if (reg_en !== 1'b1)   begin errors++; $display("[TB] FAIL midreset_pre_reg_en: got %b expected 1", reg_en); end
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        checks++; if (reg_en !== 1'b0)   begin errors++; $display("[TB] FAIL midreset_reg_en: got %b expected 0", reg_en); end
        checks++; if (ack !== 4'b0000)   begin errors++; $display("[TB] FAIL midreset_ack: got %b expected 0000", ack); end
        checks++; if (reg_d !== 8'h00)   begin errors++; $display("[TB] FAIL midreset_reg_d: got %h expected 00", reg_d); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL midreset_grant: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (dut.ptr !== 2'd0)  begin errors++; $display("[TB] FAIL midreset_ptr: got %0d expected 0", dut.ptr); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_late_ack[%0d]: got %b expected 0000", c, ack); end
            checks++; if (reg_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_late_reg_en[%0d]: got %b expected 0", c, reg_en); end
        end
    endtask

    task automatic test_idle();
        req = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL idle_busy[%0d]: got %b expected 0", c, busy); end
            checks++; if (reg_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_reg_en[%0d]: got %b expected 0", c, reg_en); end
            checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL idle_ack[%0d]: got %b expected 0000", c, ack); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_withdraw();
        test_reset_mid_write();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one enabled D-register bank; legal range 2..16.
REQ-002 Parameter W, default 8: data width of the shared register bank (W enabled flip-flops driven in parallel).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 req  input  N_REQ  per-requester write request, level; bit i held high until ack[i].
REQ-006 req_data  input  N_REQ*W  flattened write data; slice i = bits [i*W +: W].
REQ-007 ack  output  N_REQ  one-hot, one-cycle pulse marking completion of requester i's write.
REQ-008 reg_en  output  1  enable to the shared register bank, registered.
REQ-009 reg_d  output  W  data to the shared register bank, registered.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 grant_id  output  $clog2(N_REQ)  index of current or last granted requester.

Function
REQ-012 FSM states: IDLE, WRITE, ACK; encoding from package enum.
REQ-013 IDLE: if req != 0 at a posedge, select winner w, latch w into grant_id, latch req_data slice w into reg_d, go WRITE; else stay IDLE.
REQ-014 Winner selection: round-robin; lowest index i >= ptr with req[i]=1, else wrap to lowest index < ptr with req[i]=1.
REQ-015 WRITE: reg_en=1 for exactly this one cycle; next state ACK unconditionally.
REQ-016 ACK: ack[grant_id]=1 for exactly this one cycle; ptr <= (grant_id+1) mod N_REQ; next state IDLE.
REQ-017 Latency: req rise seen in IDLE at edge k -> reg_en high in cycle k+1 -> ack high in cycle k+2; max throughput one write per 3 cycles.
REQ-018 reg_d holds its latched value outside WRITE; only reg_en qualifies a write.
REQ-019 Outside WRITE reg_en=0; outside ACK ack=0; ack never has more than one bit set.
REQ-020 req_data changes after the IDLE->WRITE edge do not affect the write in progress.
REQ-021 Request withdrawn during WRITE/ACK: write and ack still complete (committed once latched).
REQ-022 Requester holding req high through ack: re-arbitrated in next IDLE like any other, subject to pointer rotation.
REQ-023 Pointer wrap: grant_id = N_REQ-1 gives ptr = 0.
REQ-024 Starvation-free: any held request granted within N_REQ arbitration rounds.

Reset
REQ-025 On reset assertion, asynchronously: state=IDLE, ptr=0, grant_id=0, reg_d=0, reg_en=0, ack=0, busy=0.
REQ-026 Reset mid-WRITE or mid-ACK aborts the transaction; no reg_en or ack pulse appears after reset; requester must re-request.
REQ-027 First arbitration no earlier than the first posedge after reset deassertion.

Structure
REQ-028 Package reg_write_arbiter_pkg holds the FSM state enum and default N_REQ/W constants.
REQ-029 Sub-module rr_pick (combinational round-robin picker: req, ptr -> valid, index) is instantiated once.
REQ-030 All outputs driven from flops; no combinational path from req to reg_en or ack.

Verification (N_REQ=4, W=8)
REQ-031 Single: req=0001, data0=0x5A -> reg_en=1 with reg_d=0x5A one cycle later, ack=0001 the next cycle, ptr=1.
REQ-032 Contention: req=1111 held with data i=0x10+i -> grant order 0,1,2,3,0; ack every third cycle; reg_d sequence 0x10,0x11,0x12,0x13,0x10.
REQ-033 Wrap: ptr=3, req=0101 -> grant 0 (wrap), then ptr=1 -> grant 2.
REQ-034 Withdrawal/data change: req2 dropped and data2 changed to 0xFF during WRITE -> reg_d keeps latched 0x33, ack=0100 still issued.
REQ-035 Reset mid-WRITE: reset asserted while reg_en=1 -> reg_en, ack, reg_d, grant_id all 0 immediately; no ack after release; ptr=0.
REQ-036 Idle: req=0000 for 20 cycles -> busy=0, reg_en=0, ack=0 throughout.
